rs_pulse_driver: RTL
====================

# rs_pulse_driver

Upstream driver for the `rs` NAND set/reset latch. It synchronizes and debounces two raw request inputs. It converts each debounced rising edge into a fixed-width active-low strobe on `s_n` or `r_n`, and guarantees the two strobes are never low together. It also checks the latch's `q` feedback after every strobe and flags any disagreement with the expected state.

## Interface
- `DEB_CYCLES`, default 4: consecutive identical synchronized samples required before a debounced level changes; legal range ≥1.
- `PULSE_W`, default 3: strobe low time in clock cycles; legal range ≥1.
- `GAP_W`, default 2: cycles both strobes are held high after a strobe, before `q` is checked or the next strobe starts; legal range ≥1.
- `clk` input, 1 bit: single clock; all state updates on the rising edge.
- `rst_n` input, 1 bit: reset, synchronous and active-low.
- `set_req` input, 1 bit: raw, asynchronous, bouncy set request; active-high.
- `reset_req` input, 1 bit: raw, asynchronous, bouncy reset request; active-high.
- `q` input, 1 bit: latch output fed back; asynchronous, so it is 2-flop synchronized internally.
- `s_n` output, 1 bit: active-low set strobe to the latch.
- `r_n` output, 1 bit: active-low reset strobe to the latch.
- `busy` output, 1 bit: high while the FSM is not in IDLE.
- `expect_q` output, 1 bit: latch state implied by the last strobe issued.
- `mismatch` output, 1 bit: one-cycle pulse when the synchronized `q` differs from `expect_q` at check time.

## Operation
- **Reset.** Applies when `rst_n`=0 at a clock edge, in any state and mid-strobe.
  - Outputs: `s_n`=1, `r_n`=1, `busy`=0, `expect_q`=0, `mismatch`=0.
  - Internal: synchronizers cleared to 0, debounced levels 0, counters 0, pending flags cleared, FSM in IDLE.
  - An in-flight strobe is cut off at that edge.
- **Synchronization.** Each of `set_req`, `reset_req` and `q` passes through its own 2-flop synchronizer.
- **Debounce (per request channel).**
  - A counter increments while the synchronized sample differs from the debounced level.
  - The counter clears whenever the sample equals the debounced level.
  - When the counter reaches DEB_CYCLES, the debounced level flips and the counter clears.
  - A 0→1 flip of a debounced level produces a one-cycle event (`set_ev` or `reset_ev`). Release (1→0) produces no event.
  - Counter width is the minimal width that can hold the value DEB_CYCLES.
- **Pending flags.**
  - `set_pend` and `reset_pend` are each set by the matching event in any FSM state.
  - A flag is cleared when its strobe is launched.
  - Several events of one type while that flag is already set collapse into one.
- **FSM states: IDLE, STROBE, GAP, CHECK.**
  - IDLE → STROBE when either pending flag is set, or an event arrives that cycle.
    - If both are present, reset wins; the set request stays pending.
    - Launching a reset strobe drives `r_n`=0 and sets `expect_q`=0.
    - Launching a set strobe drives `s_n`=0 and sets `expect_q`=1.
  - STROBE: the selected strobe is held low for exactly PULSE_W cycles, then → GAP with both strobes high.
  - GAP: both strobes high for exactly GAP_W cycles, then → CHECK.
  - CHECK: one cycle. `mismatch` is registered as (synchronized `q` != `expect_q`) and is visible the cycle after CHECK. Then → IDLE.
  - Pending requests are launched from IDLE, the cycle after CHECK.
- **Invariant.** `s_n` and `r_n` are never both 0, including across reset and back-to-back requests.
- Phase counter width is sized for max(PULSE_W, GAP_W).
- All outputs are registered; there is no combinational path from input to output.

## Timing
- **Strobe latency.** Let E0 be the first edge at which `set_req`=1 is sampled, with `set_req` held high and the FSM idle. The strobe goes low after edge E0+DEB_CYCLES+2 (2 synchronizer stages, DEB_CYCLES debounce cycles, 1 output register).
- **Strobe length.** The strobe is low for PULSE_W edges. `busy` rises on the same edge the strobe falls.
- **Back-to-back strobes.** The minimum spacing between two strobe launches is PULSE_W+GAP_W+2 cycles (strobe, gap, CHECK, IDLE).
- **`mismatch` timing.** `mismatch` is high for exactly one cycle. `busy` falls on the edge leaving CHECK.
- **Debounce rejection.** A glitch shorter than DEB_CYCLES synchronized cycles produces no event.

## Test plan
- **Reset values.** Hold `rst_n`=0 for 3 cycles with both requests high.
  - → `s_n`=1, `r_n`=1, `busy`=0, `expect_q`=0, `mismatch`=0 throughout.
- **Single set, defaults.** `set_req` rises and is held, first sampled at E0.
  - → `s_n` low after E0+6, for exactly 3 cycles.
  - → `expect_q`=1.
  - → With the latch model returning `q`=1, `mismatch` stays 0.
- **Bounce rejection.** `set_req` pulses 1-0-1-0 with 2-cycle periods, then stays 0.
  - → No strobe and `busy`=0.
  - Then hold `set_req` high → exactly one strobe.
- **Simultaneous requests.** `set_req` and `reset_req` rise on the same edge.
  - → `r_n` strobe first.
  - → `s_n` strobe launched 7 cycles after the `r_n` strobe launch.
  - → `s_n`&`r_n` never both 0.
  - → Final `expect_q`=1.
- **Mismatch detection.** Issue a set with the `q` feedback forced to 0.
  - → `mismatch`=1 for exactly one cycle, the cycle after CHECK.
  - → `expect_q` remains 1.
- **Reset mid-strobe.** Assert `rst_n`=0 during the 2nd low cycle of `s_n`.
  - → `s_n`=1 at the next edge, and all reset values hold.
  - → No strobe after release until a fresh debounced rising edge arrives.

Source files
------------

// File: rtl/rs_pulse_driver.sv
`default_nettype none
// ============================================================================
//  Module      : rs_pulse_driver
//  Description : Upstream driver for a NAND set/reset latch. It synchronizes
//                and debounces raw set/reset requests, then issues
//                fixed-width active-low strobes on s_n / r_n that are never
//                low together. After each strobe it checks the latch q
//                feedback against the expected state.
//  Revision    : 1.0 - initial release
// ============================================================================
module rs_pulse_driver #(
    parameter int DEB_CYCLES = 4,
    parameter int PULSE_W    = 3,
    parameter int GAP_W      = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic set_req,
    input  logic reset_req,
    input  logic q,
    output logic s_n,
    output logic r_n,
    output logic busy,
    output logic expect_q,
    output logic mismatch
);

    // Debounce counter must be able to hold DEB_CYCLES itself.
    localparam int c_CNT_W  = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES + 1) : 1;
    // The phase counter serves both the strobe and gap windows.
    localparam int c_PH_MAX = (PULSE_W > GAP_W) ? PULSE_W : GAP_W;
    localparam int c_PH_W   = (c_PH_MAX > 1) ? $clog2(c_PH_MAX + 1) : 1;

    // The level flips on the edge where the count would reach DEB_CYCLES.
    localparam logic [c_CNT_W-1:0] c_DEB_LAST   = c_CNT_W'(DEB_CYCLES - 1);
    localparam logic [c_PH_W-1:0]  c_PULSE_LAST = c_PH_W'(PULSE_W - 1);
    localparam logic [c_PH_W-1:0]  c_GAP_LAST   = c_PH_W'(GAP_W - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STROBE = 2'd1,
        ST_GAP    = 2'd2,
        ST_CHECK  = 2'd3
    } state_t;

    // Synchronizer stages
    logic r_set_s1, r_set_s2;
    logic r_rst_s1, r_rst_s2;
    logic r_q_s1,   r_q_s2;

    // Debounce state per request channel
    logic [c_CNT_W-1:0] r_set_cnt, r_rst_cnt;
    logic               r_set_lvl, r_rst_lvl;
    logic               r_set_ev,  r_rst_ev;

    // Request bookkeeping and sequencing
    logic               r_set_pend, r_rst_pend;
    state_t             r_state;
    logic [c_PH_W-1:0]  r_ph;

    // Registered outputs
    logic r_s_n, r_r_n, r_busy, r_expect_q, r_mismatch;

    // A request is serviceable if it is already pending or arriving right now.
    logic w_set_any, w_rst_any;
    assign w_set_any = r_set_pend | r_set_ev;
    assign w_rst_any = r_rst_pend | r_rst_ev;

    // Two-flop synchronizers for the asynchronous requests and latch feedback.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_set_s1 <= 1'b0;
            r_set_s2 <= 1'b0;
            r_rst_s1 <= 1'b0;
            r_rst_s2 <= 1'b0;
            r_q_s1   <= 1'b0;
            r_q_s2   <= 1'b0;
        end else begin
            r_set_s1 <= set_req;
            r_set_s2 <= r_set_s1;
            r_rst_s1 <= reset_req;
            r_rst_s2 <= r_rst_s1;
            r_q_s1   <= q;
            r_q_s2   <= r_q_s1;
        end
    end

    // Set channel debounce; a one-cycle event marks each debounced rise.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_set_cnt <= '0;
            r_set_lvl <= 1'b0;
            r_set_ev  <= 1'b0;
        end else begin
            r_set_ev <= 1'b0;
            if (r_set_s2 == r_set_lvl) begin
                r_set_cnt <= '0;
            end else if (r_set_cnt == c_DEB_LAST) begin
                r_set_lvl <= r_set_s2;
                r_set_cnt <= '0;
                r_set_ev  <= r_set_s2;
            end else begin
                r_set_cnt <= r_set_cnt + 1'b1;
            end
        end
    end

    // Reset channel debounce; a one-cycle event marks each debounced rise.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rst_cnt <= '0;
            r_rst_lvl <= 1'b0;
            r_rst_ev  <= 1'b0;
        end else begin
            r_rst_ev <= 1'b0;
            if (r_rst_s2 == r_rst_lvl) begin
                r_rst_cnt <= '0;
            end else if (r_rst_cnt == c_DEB_LAST) begin
                r_rst_lvl <= r_rst_s2;
                r_rst_cnt <= '0;
                r_rst_ev  <= r_rst_s2;
            end else begin
                r_rst_cnt <= r_rst_cnt + 1'b1;
            end
        end
    end

    // Strobe sequencer: launch, hold strobe, hold gap, check feedback.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_ph       <= '0;
            r_set_pend <= 1'b0;
            r_rst_pend <= 1'b0;
            r_s_n      <= 1'b1;
            r_r_n      <= 1'b1;
            r_busy     <= 1'b0;
            r_expect_q <= 1'b0;
            r_mismatch <= 1'b0;
        end else begin
            r_mismatch <= 1'b0;
            // Events latch into pending flags in every state; repeats collapse.
            r_set_pend <= w_set_any;
            r_rst_pend <= w_rst_any;
            case (r_state)
                ST_IDLE: begin
                    // Reset has priority; a concurrent set stays pending.
                    if (w_rst_any) begin
                        r_rst_pend <= 1'b0;
                        r_r_n      <= 1'b0;
                        r_expect_q <= 1'b0;
                        r_busy     <= 1'b1;
                        r_ph       <= '0;
                        r_state    <= ST_STROBE;
                    end else if (w_set_any) begin
                        r_set_pend <= 1'b0;
                        r_s_n      <= 1'b0;
                        r_expect_q <= 1'b1;
                        r_busy     <= 1'b1;
                        r_ph       <= '0;
                        r_state    <= ST_STROBE;
                    end
                end
                ST_STROBE: begin
                    if (r_ph == c_PULSE_LAST) begin
                        r_s_n   <= 1'b1;
                        r_r_n   <= 1'b1;
                        r_ph    <= '0;
                        r_state <= ST_GAP;
                    end else begin
                        r_ph <= r_ph + 1'b1;
                    end
                end
                ST_GAP: begin
                    if (r_ph == c_GAP_LAST) begin
                        r_ph    <= '0;
                        r_state <= ST_CHECK;
                    end else begin
                        r_ph <= r_ph + 1'b1;
                    end
                end
                ST_CHECK: begin
                    r_mismatch <= (r_q_s2 != r_expect_q);
                    r_busy     <= 1'b0;
                    r_state    <= ST_IDLE;
                end
                default: begin
                    r_s_n   <= 1'b1;
                    r_r_n   <= 1'b1;
                    r_busy  <= 1'b0;
                    r_ph    <= '0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign s_n      = r_s_n;
    assign r_n      = r_r_n;
    assign busy     = r_busy;
    assign expect_q = r_expect_q;
    assign mismatch = r_mismatch;

endmodule
`default_nettype wire
